// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-control unit: sequential, relative branch, absolute jump,
// and call/return through an internal return-address stack, with imem back-pressure stall.
module pc_fetch_ctrl #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned OFF_W     = 4,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic             CLK,
    input  logic             Init_n,
    input  logic             Halt,
    input  logic             IMemReady,
    input  logic             Beq,
    input  logic             ALUZero,
    input  logic [OFF_W-1:0] TargetRelative,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Ret,
    input  logic [PC_W-1:0]  TargetAbsolute,
    output logic [PC_W-1:0]  PC,
    output logic             FetchValid,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasErr
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             ras_err_q, ras_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic             push_en;
    logic             ras_empty_c;
    logic             ras_full_c;

    // Address arithmetic wraps naturally at PC_W bits.
    always_comb begin
        pc_inc      = pc_q + PC_W'(1);
        off_ext     = PC_W'($signed(TargetRelative));
        top_idx     = IDX_W'(cnt_q - CNT_W'(1));
        push_idx    = IDX_W'(cnt_q);
        ras_empty_c = (cnt_q == CNT_W'(0));
        ras_full_c  = (cnt_q == CNT_W'(RAS_DEPTH));
    end

    // Next-state selection in fixed priority order: stall, Ret, Call, Jump, branch, sequential.
    always_comb begin
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        ras_err_d     = ras_err_q;
        fetch_valid_d = 1'b0;
        push_en       = 1'b0;
        if (!Halt && IMemReady) begin
            fetch_valid_d = 1'b1;
            if (Ret) begin
                if (ras_empty_c) begin
                    pc_d      = pc_inc;
                    ras_err_d = 1'b1;
                end else begin
                    pc_d  = ras_q[top_idx];
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (Call) begin
                if (ras_full_c) begin
                    ras_err_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                pc_d = TargetAbsolute;
            end else if (Jump) begin
                pc_d = TargetAbsolute;
            end else if (Beq && ALUZero) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            pc_q          <= PC_W'(RESET_PC);
            fetch_valid_q <= 1'b0;
            ras_err_q     <= 1'b0;
            cnt_q         <= CNT_W'(0);
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            ras_err_q     <= ras_err_d;
            cnt_q         <= cnt_d;
        end
    end

    // Stack entries carry no reset; only entries below the count are meaningful.
    always_ff @(posedge CLK) begin
        if (Init_n && push_en) begin
            ras_q[push_idx] <= pc_inc;
        end
    end

    assign PC         = pc_q;
    assign FetchValid = fetch_valid_q;
    assign RasErr     = ras_err_q;
    assign RasEmpty   = ras_empty_c;
    assign RasFull    = ras_full_c;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a driver pushes model-predicted state per cycle,
// a monitor pops and compares after each rising edge.
module tb_pc_fetch_ctrl;

    logic       clk;
    logic       init_n, halt, imem_ready, beq, alu_zero, jump, call, ret;
    logic [3:0] t_rel;
    logic [7:0] t_abs;
    logic [7:0] pc;
    logic       fetch_valid, ras_empty, ras_full, ras_err;

    pc_fetch_ctrl #(.PC_W(8), .OFF_W(4), .RAS_DEPTH(4), .RESET_PC(0)) dut (
        .CLK(clk), .Init_n(init_n), .Halt(halt), .IMemReady(imem_ready),
        .Beq(beq), .ALUZero(alu_zero), .TargetRelative(t_rel), .Jump(jump),
        .Call(call), .Ret(ret), .TargetAbsolute(t_abs), .PC(pc),
        .FetchValid(fetch_valid), .RasEmpty(ras_empty), .RasFull(ras_full), .RasErr(ras_err)
    );

    typedef struct {
        int    pc;
        bit    fv;
        bit    emp;
        bit    full;
        bit    err;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_pc  = 0;
    int m_ras[$];
    bit m_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input bit i_n, input bit h, input bit rdy, input bit b, input bit z,
                        input int rel, input bit j, input bit c, input bit r, input int abs_t,
                        input string tag);
        exp_t e;
        int   soff;
        @(negedge clk);
        init_n = i_n; halt = h; imem_ready = rdy; beq = b; alu_zero = z;
        t_rel = 4'(rel); jump = j; call = c; ret = r; t_abs = 8'(abs_t);
        e.fv = 1'b0;
        if (!i_n) begin
            m_pc = 0; m_ras.delete(); m_err = 0;
        end else if (h || !rdy) begin
            e.fv = 1'b0;
        end else begin
            e.fv = 1'b1;
            if (r) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin m_pc = (m_pc + 1) % 256; m_err = 1; end
            end else if (c) begin
                if (m_ras.size() < 4) m_ras.push_back((m_pc + 1) % 256);
                else m_err = 1;
                m_pc = abs_t % 256;
            end else if (j) begin
                m_pc = abs_t % 256;
            end else if (b && z) begin
                soff = (rel % 16 >= 8) ? (rel % 16) - 16 : rel % 16;
                m_pc = (m_pc + soff + 256) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
        e.pc   = m_pc;
        e.emp  = (m_ras.size() == 0);
        e.full = (m_ras.size() == 4);
        e.err  = m_err;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    // Monitor: compare DUT state shortly after every rising edge that has a pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc !== 8'(e.pc) || fetch_valid !== e.fv || ras_empty !== e.emp ||
                ras_full !== e.full || ras_err !== e.err) begin
                failures++;
                $display("FAIL %s: got pc=%0h fv=%b emp=%b full=%b err=%b, want pc=%0h fv=%b emp=%b full=%b err=%b",
                         e.tag, pc, fetch_valid, ras_empty, ras_full, ras_err,
                         e.pc, e.fv, e.emp, e.full, e.err);
            end
        end
    end

    initial begin
        init_n = 0; halt = 0; imem_ready = 1; beq = 0; alu_zero = 0;
        t_rel = '0; jump = 0; call = 0; ret = 0; t_abs = '0;

        // Reset then sequential count
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 5; i++) idle("seq");

        // Relative branch taken / not taken from PC=10
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 10, "jump10");
        step(1, 0, 1, 1, 1, 13, 0, 0, 0, 0, "beq_taken");
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 10, "jump10b");
        step(1, 0, 1, 1, 0, 13, 0, 0, 0, 0, "beq_not_taken");

        // Wrap boundaries
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 255, "jump_ff");
        idle("wrap_inc");
        step(1, 0, 1, 1, 1, 15, 0, 0, 0, 0, "wrap_neg");

        // Call / return
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 20, "jump20");
        step(1, 0, 1, 0, 0, 0, 0, 1, 0, 50, "call50");
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "ret21");

        // Nested calls past depth, then unwinding past empty
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 1, 0, 100 + 10 * i, "nest_call");
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "nest_ret");

        // Stalls with Call+Jump asserted; reset concurrent with Call
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "reset2");
        step(1, 0, 1, 0, 0, 0, 0, 1, 0, 40, "call40");
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, 77, "halt_hold");
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 77, "stall_hold");
        step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, "ret_after_stall");
        step(1, 0, 1, 0, 0, 0, 0, 1, 0, 90, "call90");
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 60, "reset_with_call");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 15), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 255), "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
